// File: rtl/fsm_controller_ws.sv
`default_nettype none
// ============================================================================
// Module   : fsm_controller_ws
// Purpose  : Accumulator-CPU sequencer with memory wait states, wait timeout
//            (sticky FAULT), HALTED/resume and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_controller_ws #(
    parameter int MEM_WAIT = 0,
    parameter int TIMEOUT  = 16,
    parameter int IC_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      op,
    input  logic            zero,
    input  logic            mem_ready,
    input  logic            resume,
    output logic            mem_rd,
    output logic            load_ir,
    output logic            halt,
    output logic            inc_pc,
    output logic            load_ac,
    output logic            load_pc,
    output logic            mem_wr,
    output logic            fault,
    output logic [3:0]      state,
    output logic [IC_W-1:0] instr_count
);

    localparam int c_CNT_MAX = (TIMEOUT > MEM_WAIT) ? TIMEOUT : MEM_WAIT;
    localparam int c_CW      = $clog2(c_CNT_MAX + 2);

    localparam logic [2:0] c_OP_HLT = 3'b000;
    localparam logic [2:0] c_OP_SKZ = 3'b001;
    localparam logic [2:0] c_OP_STO = 3'b110;
    localparam logic [2:0] c_OP_JMP = 3'b111;

    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8,
        S_FAULT      = 4'd9
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [c_CW-1:0] r_wait_cnt;
    logic [IC_W-1:0] r_instr_count;
    logic            w_aluop;
    logic            w_waiting;
    logic            w_min_met;
    logic            w_timeout;
    logic            w_hold;

    assign w_aluop = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);

    generate
        if (MEM_WAIT == 0) begin : g_no_min_wait
            assign w_min_met = 1'b1;
        end else begin : g_min_wait
            localparam logic [c_CW-1:0] c_MEM_WAIT = c_CW'(MEM_WAIT);
            assign w_min_met = (r_wait_cnt >= c_MEM_WAIT);
        end
        if (TIMEOUT == 0) begin : g_no_timeout
            assign w_timeout = 1'b0;
        end else begin : g_timeout
            localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT - 1);
            assign w_timeout = (r_wait_cnt == c_TO_LAST);
        end
    endgenerate

    always_comb begin
        w_waiting = 1'b0;
        case (r_state)
            S_INST_FETCH: w_waiting = 1'b1;
            S_OP_FETCH:   w_waiting = w_aluop;
            S_STORE:      w_waiting = (op == c_OP_STO);
            default:      w_waiting = 1'b0;
        endcase
    end

    // A waiting state holds until memory is ready and the minimum wait elapsed
    assign w_hold = w_waiting && !(mem_ready && w_min_met);

    always_comb begin
        w_next = S_INST_ADDR;
        case (r_state)
            S_INST_ADDR:  w_next = S_INST_FETCH;
            S_INST_FETCH: w_next = S_INST_LOAD;
            S_INST_LOAD:  w_next = S_IDLE;
            S_IDLE:       w_next = S_OP_ADDR;
            S_OP_ADDR:    w_next = (op == c_OP_HLT) ? S_HALTED : S_OP_FETCH;
            S_OP_FETCH:   w_next = S_ALU_OP;
            S_ALU_OP:     w_next = S_STORE;
            S_STORE:      w_next = S_INST_ADDR;
            S_HALTED:     w_next = resume ? S_INST_ADDR : S_HALTED;
            S_FAULT:      w_next = S_FAULT;
            default:      w_next = S_INST_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_INST_ADDR;
            r_wait_cnt    <= '0;
            r_instr_count <= '0;
        end else if (w_hold) begin
            if (w_timeout) begin
                r_state    <= S_FAULT;
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != '1) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= '0;
            if (r_state == S_STORE) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        fault   = 1'b0;
        case (r_state)
            S_INST_FETCH: mem_rd = 1'b1;
            S_INST_LOAD, S_IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            S_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (op == c_OP_HLT);
            end
            S_OP_FETCH: mem_rd = w_aluop;
            S_ALU_OP: begin
                mem_rd  = w_aluop;
                load_ac = w_aluop;
                inc_pc  = (op == c_OP_SKZ) && zero;
                load_pc = (op == c_OP_JMP);
            end
            S_STORE: begin
                mem_rd  = w_aluop;
                load_ac = w_aluop;
                inc_pc  = (op == c_OP_JMP);
                load_pc = (op == c_OP_JMP);
                mem_wr  = (op == c_OP_STO);
            end
            S_HALTED: halt  = 1'b1;
            S_FAULT:  fault = 1'b1;
            default: ;
        endcase
    end

    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_fsm_controller_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_controller_ws
// Purpose  : Scoreboard bench for fsm_controller_ws (zero-wait and 2-wait DUTs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_controller_ws;

    localparam logic [2:0] c_HLT = 3'd0, c_SKZ = 3'd1, c_ADD = 3'd2, c_AND = 3'd3;
    localparam logic [2:0] c_XOR = 3'd4, c_LDA = 3'd5, c_STO = 3'd6, c_JMP = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] op = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       resume = 1'b0;

    logic a_mem_rd, a_load_ir, a_halt, a_inc_pc, a_load_ac, a_load_pc, a_mem_wr, a_fault;
    logic b_mem_rd, b_load_ir, b_halt, b_inc_pc, b_load_ac, b_load_pc, b_mem_wr, b_fault;
    logic [3:0]  a_state, b_state;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;
    logic [7:0]  a_ctl, b_ctl;

    always #5 clk = ~clk;

    fsm_controller_ws #(.MEM_WAIT(0), .TIMEOUT(16), .IC_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready), .resume(resume),
        .mem_rd(a_mem_rd), .load_ir(a_load_ir), .halt(a_halt), .inc_pc(a_inc_pc),
        .load_ac(a_load_ac), .load_pc(a_load_pc), .mem_wr(a_mem_wr), .fault(a_fault),
        .state(a_state), .instr_count(a_cnt)
    );

    fsm_controller_ws #(.MEM_WAIT(2), .TIMEOUT(16), .IC_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready), .resume(resume),
        .mem_rd(b_mem_rd), .load_ir(b_load_ir), .halt(b_halt), .inc_pc(b_inc_pc),
        .load_ac(b_load_ac), .load_pc(b_load_pc), .mem_wr(b_mem_wr), .fault(b_fault),
        .state(b_state), .instr_count(b_cnt)
    );

    // {fault, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
    assign a_ctl = {a_fault, a_mem_rd, a_load_ir, a_halt, a_inc_pc, a_load_ac, a_load_pc, a_mem_wr};
    assign b_ctl = {b_fault, b_mem_rd, b_load_ir, b_halt, b_inc_pc, b_load_ac, b_load_pc, b_mem_wr};

    typedef struct {
        string       tag;
        logic        sel;
        logic [3:0]  st;
        logic [7:0]  ctl;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] ecnt = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctl_for(input logic [3:0] st, input logic [2:0] o, input logic z);
        logic alu;
        alu = (o == c_ADD) || (o == c_AND) || (o == c_XOR) || (o == c_LDA);
        case (st)
            4'd1:       return 8'h40;
            4'd2, 4'd3: return 8'h60;
            4'd4:       return 8'h08 | ((o == c_HLT) ? 8'h10 : 8'h00);
            4'd5:       return alu ? 8'h40 : 8'h00;
            4'd6:       return (alu ? 8'h44 : 8'h00) | ((o == c_SKZ && z) ? 8'h08 : 8'h00)
                               | ((o == c_JMP) ? 8'h02 : 8'h00);
            4'd7:       return (alu ? 8'h44 : 8'h00) | ((o == c_JMP) ? 8'h0A : 8'h00)
                               | ((o == c_STO) ? 8'h01 : 8'h00);
            4'd8:       return 8'h10;
            4'd9:       return 8'h80;
            default:    return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            if (m_e.sel == 1'b0) begin
                chk({m_e.tag, ".a.state"}, {28'd0, a_state}, {28'd0, m_e.st});
                chk({m_e.tag, ".a.ctl"},   {24'd0, a_ctl},   {24'd0, m_e.ctl});
                chk({m_e.tag, ".a.cnt"},   {16'd0, a_cnt},   {16'd0, m_e.cnt});
            end else begin
                chk({m_e.tag, ".b.state"}, {28'd0, b_state}, {28'd0, m_e.st});
                chk({m_e.tag, ".b.ctl"},   {24'd0, b_ctl},   {24'd0, m_e.ctl});
                chk({m_e.tag, ".b.cnt"},   {28'd0, b_cnt},   {28'd0, m_e.cnt[3:0]});
            end
        end
    end

    task automatic tick(input string tag, input logic sel, input logic [3:0] st);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.st  = st;
        e.ctl = ctl_for(st, op, zero);
        e.cnt = ecnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ecnt = 16'd0;
    endtask

    task automatic instr_a(input string tag, input logic [2:0] o, input logic z);
        op = o;
        zero = z;
        mem_ready = 1'b1;
        for (int s = 0; s < 8; s++) tick(tag, 1'b0, 4'(s));
        ecnt++;
    endtask

    task automatic instr_b(input string tag, input logic [2:0] o);
        op = o;
        zero = 1'b0;
        mem_ready = 1'b1;
        tick(tag, 1'b1, 4'd0);
        repeat (3) tick(tag, 1'b1, 4'd1);
        tick(tag, 1'b1, 4'd2);
        tick(tag, 1'b1, 4'd3);
        tick(tag, 1'b1, 4'd4);
        repeat ((o == c_ADD || o == c_AND || o == c_XOR || o == c_LDA) ? 3 : 1) tick(tag, 1'b1, 4'd5);
        tick(tag, 1'b1, 4'd6);
        repeat ((o == c_STO) ? 3 : 1) tick(tag, 1'b1, 4'd7);
        ecnt++;
    endtask

    logic [2:0] ops_b [7];

    initial begin
        ops_b = '{c_ADD, c_AND, c_XOR, c_LDA, c_SKZ, c_JMP, c_STO};
        #2;
        chk("rst.a.state", {28'd0, a_state}, 32'd0);
        chk("rst.a.ctl",   {24'd0, a_ctl},   32'd0);
        chk("rst.a.cnt",   {16'd0, a_cnt},   32'd0);
        chk("rst.b.state", {28'd0, b_state}, 32'd0);
        reset_all();

        // Zero-wait instruction mix, resume ignored outside HALTED
        instr_a("add", c_ADD, 1'b0);
        instr_a("skz1", c_SKZ, 1'b1);
        instr_a("skz0", c_SKZ, 1'b0);
        instr_a("jmp", c_JMP, 1'b0);
        instr_a("sto", c_STO, 1'b0);
        resume = 1'b1;
        instr_a("and_res", c_AND, 1'b1);
        resume = 1'b0;
        instr_a("xor", c_XOR, 1'b0);
        instr_a("lda", c_LDA, 1'b0);

        // HLT: held in HALTED until resume, not counted
        op = c_HLT;
        for (int s = 0; s < 5; s++) tick("hlt", 1'b0, 4'(s));
        repeat (10) tick("halted", 1'b0, 4'd8);
        resume = 1'b1;
        tick("resume", 1'b0, 4'd8);
        resume = 1'b0;
        op = c_ADD;
        for (int s = 0; s < 8; s++) tick("post_hlt", 1'b0, 4'(s));
        ecnt++;
        tick("post_hlt_cnt", 1'b0, 4'd0);

        // Asynchronous reset in the middle of an OP_FETCH wait
        for (int s = 1; s < 5; s++) tick("midwait", 1'b0, 4'(s));
        mem_ready = 1'b0;
        repeat (3) tick("opf_wait", 1'b0, 4'd5);
        rst = 1'b0;
        #2;
        chk("arst.state", {28'd0, a_state}, 32'd0);
        chk("arst.ctl",   {24'd0, a_ctl},   32'd0);
        chk("arst.cnt",   {16'd0, a_cnt},   32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ecnt = 16'd0;

        // Timeout: 16 cycles in INST_FETCH without mem_ready -> sticky FAULT
        op = c_ADD;
        mem_ready = 1'b0;
        tick("to", 1'b0, 4'd0);
        repeat (16) tick("to_wait", 1'b0, 4'd1);
        mem_ready = 1'b1;
        repeat (3) tick("fault", 1'b0, 4'd9);
        rst = 1'b0;
        #2;
        chk("fault_rst.state", {28'd0, a_state}, 32'd0);
        chk("fault_rst.fault", {31'd0, a_fault}, 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ecnt = 16'd0;

        // mem_ready on the last permitted cycle wins over the timeout
        mem_ready = 1'b0;
        tick("to2", 1'b0, 4'd0);
        repeat (15) tick("to2_wait", 1'b0, 4'd1);
        mem_ready = 1'b1;
        tick("to2_last", 1'b0, 4'd1);
        tick("to2_adv", 1'b0, 4'd2);
        tick("to2_adv", 1'b0, 4'd3);

        // MEM_WAIT=2 instance, then wrap of its 4-bit counter
        reset_all();
        instr_b("w_sto", c_STO);
        instr_b("w_add", c_ADD);
        for (int i = 0; i < 14; i++) instr_b("w_mix", ops_b[i % 7]);
        op = c_ADD;
        tick("w_wrap", 1'b1, 4'd0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
